// File: rtl/dut_probe_pkg.sv
// Shared types and constants for the probe selector / capture engine.
// Imported by dut_probe_capture.
package dut_probe_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_e;

    localparam logic [1:0] TRIG_IMMEDIATE = 2'd0;
    localparam logic [1:0] TRIG_RISING    = 2'd1;
    localparam logic [1:0] TRIG_FALLING   = 2'd2;
    localparam logic [1:0] TRIG_LEVEL     = 2'd3;

endpackage

// File: rtl/dut_capture_ram.sv
// DEPTH x 1 simple dual-port RAM: one write port, one registered read port.
// A same-cycle read of the address being written returns the old contents.
module dut_capture_ram #(
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic                  wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic                  rdata
);

    logic mem [DEPTH];

    // NOTE: the array itself has no reset so it can map onto block RAM;
    // only the read-data register is cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= 1'b0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/dut_probe_capture.sv
// Live probe selector with an arm/trigger capture engine that stores DEPTH
// consecutive samples of the selected probe bit for readback by address.
module dut_probe_capture
    import dut_probe_pkg::*;
#(
    parameter int SIGNAL_COUNT = 32,
    parameter int SELECT_WIDTH = 5,
    parameter int DEPTH        = 1024,
    parameter int ADDR_WIDTH   = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SIGNAL_COUNT-1:0] probe_signals,
    input  logic [SELECT_WIDTH-1:0] dut_signal_select,
    output logic                    dut_output,
    input  logic                    arm,
    input  logic                    abort,
    input  logic [1:0]              trigger_mode,
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_WIDTH:0]     sample_count,
    input  logic [ADDR_WIDTH-1:0]   read_addr,
    output logic                    read_data
);

    localparam int                PAD_WIDTH = 2 ** SELECT_WIDTH;
    localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH + 1)'(DEPTH - 1);

    // Zero-padding to the full select range makes out-of-range selects read 0.
    logic [PAD_WIDTH-1:0] probe_padded;
    assign probe_padded = PAD_WIDTH'(probe_signals);

    state_e                  state_q, state_d;
    logic                    done_q, done_d;
    logic                    busy_d;
    logic [ADDR_WIDTH:0]     count_q, count_d;
    logic                    prev_q, prev_d;
    logic                    prev_valid_q, prev_valid_d;
    logic [SELECT_WIDTH-1:0] sel_lat_q, sel_lat_d;
    logic [1:0]              mode_q, mode_d;
    logic                    cap_q;
    logic                    arm_accept;
    logic                    trig_hit;
    logic                    wr_en;

    assign arm_accept = arm && !abort && (state_q == IDLE || state_q == DONE);

    // NOTE: every output of this block gets a default first so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        done_d       = done_q;
        count_d      = count_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        sel_lat_d    = sel_lat_q;
        mode_d       = mode_q;
        wr_en        = 1'b0;
        trig_hit     = 1'b0;

        case (mode_q)
            TRIG_IMMEDIATE: trig_hit = !prev_valid_q;
            TRIG_RISING:    trig_hit = prev_valid_q && !prev_q && cap_q;
            TRIG_FALLING:   trig_hit = prev_valid_q && prev_q && !cap_q;
            TRIG_LEVEL:     trig_hit = cap_q;
            default:        trig_hit = 1'b0;
        endcase

        if (abort) begin
            state_d = IDLE;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (arm) begin
                        state_d      = ARMED;
                        sel_lat_d    = dut_signal_select;
                        mode_d       = trigger_mode;
                        done_d       = 1'b0;
                        count_d      = '0;
                        prev_valid_d = 1'b0;
                    end
                end
                ARMED: begin
                    prev_d       = cap_q;
                    prev_valid_d = 1'b1;
                    if (trig_hit) begin
                        wr_en   = 1'b1;
                        count_d = (ADDR_WIDTH + 1)'(1);
                        state_d = CAPTURE;
                    end
                end
                CAPTURE: begin
                    wr_en   = 1'b1;
                    count_d = count_q + (ADDR_WIDTH + 1)'(1);
                    if (count_q == LAST_ADDR) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d == ARMED) || (state_d == CAPTURE);
    end

    // The arming edge samples with the incoming select so the first ARMED
    // cycle already sees the bit being captured.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            done_q       <= 1'b0;
            busy         <= 1'b0;
            count_q      <= '0;
            prev_q       <= 1'b0;
            prev_valid_q <= 1'b0;
            sel_lat_q    <= '0;
            mode_q       <= TRIG_IMMEDIATE;
            cap_q        <= 1'b0;
            dut_output   <= 1'b0;
        end else begin
            state_q      <= state_d;
            done_q       <= done_d;
            busy         <= busy_d;
            count_q      <= count_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            sel_lat_q    <= sel_lat_d;
            mode_q       <= mode_d;
            cap_q        <= probe_padded[arm_accept ? dut_signal_select : sel_lat_q];
            dut_output   <= probe_padded[dut_signal_select];
        end
    end

    assign done         = done_q;
    assign sample_count = count_q;

    dut_capture_ram #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_en),
        .waddr (count_q[ADDR_WIDTH-1:0]),
        .wdata (cap_q),
        .raddr (read_addr),
        .rdata (read_data)
    );

endmodule
